// File: rtl/adder_pkg.sv
// Shared types and constants for the multi-word add sequencer and its adder slice.
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_WORDS = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Request/result handshake bundle of the multi-word add sequencer.
interface multiword_add_sequencer_if #(
  parameter int WIDTH = adder_pkg::DEFAULT_WIDTH,
  parameter int WORDS = adder_pkg::DEFAULT_WORDS
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH*WORDS-1:0]   in_a;
  logic [WIDTH*WORDS-1:0]   in_b;
  logic                     in_cin;
  logic                     in_sub;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WORDS-1:0]   out_sum;
  logic                     out_cout;
  logic                     out_overflow;

  // Requester / result consumer side.
  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_overflow
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_overflow
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Steps an external WIDTH-bit adder slice LSB-first across WORDS slices,
// chaining carries, to add or subtract WIDTH*WORDS-bit operands.
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multiword_add_sequencer_if.slave io,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  output logic                 add_cin,
  input  logic [WIDTH-1:0]     add_sum,
  input  logic                 add_cout,
  input  logic                 add_overflow
);
  localparam int TOTAL = WIDTH * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  seq_state_e        state_q, state_d;
  logic [TOTAL-1:0]  a_q, a_d;
  logic [TOTAL-1:0]  b_q, b_d;
  logic [TOTAL-1:0]  sum_q, sum_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          a_d     = io.in_a;
          // Subtract as A + ~B + 1; the +1 enters through the first carry.
          b_d     = (io.in_sub == OP_SUB) ? ~io.in_b : io.in_b;
          carry_d = (io.in_sub == OP_SUB) ? 1'b1 : io.in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[int'(idx_q)*WIDTH +: WIDTH];
        add_b   = b_q[int'(idx_q)*WIDTH +: WIDTH];
        add_cin = carry_q;
        sum_d[int'(idx_q)*WIDTH +: WIDTH] = add_sum;
        carry_d = add_cout;
        if (idx_q == LAST) begin
          cout_d  = add_cout;
          ovf_d   = add_overflow;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io.in_ready     = in_ready_q;
  assign io.out_valid    = out_valid_q;
  assign io.out_sum      = sum_q;
  assign io.out_cout     = cout_q;
  assign io.out_overflow = ovf_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench: sequencer beside a behavioural 16-bit adder slice, WORDS=4.
module tb_multiword_add_sequencer;
  import adder_pkg::*;

  localparam int WIDTH = 16;
  localparam int WORDS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic add_cin, add_cout, add_overflow;
  logic [WIDTH:0] slice_tmp;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multiword_add_sequencer_if #(.WIDTH(WIDTH), .WORDS(WORDS)) io ();

  multiword_add_sequencer #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .io           (io.slave),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .add_overflow (add_overflow)
  );

  // Ripple-carry slice sitting beside the sequencer.
  always_comb begin
    slice_tmp    = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    add_sum      = slice_tmp[WIDTH-1:0];
    add_cout     = slice_tmp[WIDTH];
    add_overflow = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (add_sum[WIDTH-1] != add_a[WIDTH-1]);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, check first-slice drive, latency and result, then consume.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic sub,
                        input logic [15:0] exp_a0, input logic [15:0] exp_b0, input logic exp_cin0,
                        input logic [63:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    int lat;
    io.in_valid = 1'b1;
    io.in_a     = a;
    io.in_b     = b;
    io.in_cin   = cin;
    io.in_sub   = sub;
    @(negedge clk);
    io.in_valid = 1'b0;
    chk({tag, ".add_a0"},   64'(add_a), 64'(exp_a0));
    chk({tag, ".add_b0"},   64'(add_b), 64'(exp_b0));
    chk({tag, ".add_cin0"}, 64'(add_cin), 64'(exp_cin0));
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(WORDS + 1));
    chk({tag, ".sum"},  io.out_sum, exp_sum);
    chk({tag, ".cout"}, 64'(io.out_cout), 64'(exp_cout));
    chk({tag, ".ovf"},  64'(io.out_overflow), 64'(exp_ovf));
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk({tag, ".consumed_valid"}, 64'(io.out_valid), 64'd0);
    chk({tag, ".consumed_ready"}, 64'(io.in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] held_sum;
    int lat;
    rst_n        = 1'b0;
    io.in_valid  = 1'b0;
    io.in_a      = '0;
    io.in_b      = '0;
    io.in_cin    = 1'b0;
    io.in_sub    = OP_ADD;
    io.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.in_ready",  64'(io.in_ready), 64'd1);
    chk("rst.out_valid", 64'(io.out_valid), 64'd0);
    chk("rst.out_sum",   io.out_sum, 64'd0);
    chk("rst.cout",      64'(io.out_cout), 64'd0);
    chk("rst.ovf",       64'(io.out_overflow), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.add_a", 64'(add_a), 64'd0);

    run_op("carry_x", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, OP_ADD,
           16'hFFFF, 16'h0001, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, OP_ADD,
           16'hFFFF, 16'h0001, 1'b0, 64'h0, 1'b1, 1'b0);
    run_op("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, OP_ADD,
           16'hFFFF, 16'h0001, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    run_op("sub_borrow", 64'd5, 64'd7, 1'b0, OP_SUB,
           16'h0005, 16'hFFF8, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_ok", 64'd7, 64'd5, 1'b1, OP_SUB,
           16'h0007, 16'hFFFA, 1'b1, 64'h2, 1'b1, 1'b0);
    run_op("add_cin", 64'd3, 64'd4, 1'b1, OP_ADD,
           16'h0003, 16'h0004, 1'b1, 64'd8, 1'b0, 1'b0);

    // Backpressure: result held while a second request waits on in_valid.
    io.in_valid = 1'b1;
    io.in_a     = 64'h0001_0002_0003_0004;
    io.in_b     = 64'h0010_0020_0030_0040;
    io.in_cin   = 1'b0;
    io.in_sub   = OP_ADD;
    @(negedge clk);
    io.in_a = 64'd100;
    io.in_b = 64'd23;
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.latency", 64'(lat), 64'(WORDS + 1));
    held_sum = 64'h0011_0022_0033_0044;
    for (int i = 0; i < 10; i++) begin
      chk("bp.sum_hold",  io.out_sum, held_sum);
      chk("bp.in_ready",  64'(io.in_ready), 64'd0);
      chk("bp.valid_hold", 64'(io.out_valid), 64'd1);
      @(negedge clk);
    end
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;
    chk("bp.no_same_cycle_accept", 64'(io.in_ready), 64'd1);
    chk("bp.valid_dropped", 64'(io.out_valid), 64'd0);
    @(negedge clk);
    io.in_valid = 1'b0;
    chk("bp.second_accepted", 64'(io.in_ready), 64'd0);
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.second_latency", 64'(lat), 64'(WORDS + 1));
    chk("bp.second_sum", io.out_sum, 64'd123);
    io.out_ready = 1'b1;
    @(negedge clk);
    io.out_ready = 1'b0;

    // Reset while the third slice (idx=2) is on the adder.
    io.in_valid = 1'b1;
    io.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    io.in_b     = 64'h1;
    io.in_sub   = OP_ADD;
    @(negedge clk);
    io.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rr.idx2_add_a", 64'(add_a), 64'hFFFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rr.in_ready",  64'(io.in_ready), 64'd1);
    chk("rr.out_valid", 64'(io.out_valid), 64'd0);
    chk("rr.out_sum",   io.out_sum, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 64'd3, 64'd4, 1'b0, OP_ADD,
           16'h0003, 16'h0004, 1'b0, 64'd7, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Drives the 16-bit ripple-carry adder slice over several cycles to add or subtract operands WORDS×WIDTH bits wide. Each cycle it presents one operand slice, least-significant first, and feeds the slice's carry back as the next cin. It captures each sum slice into a wide result register. It sits upstream and downstream of the adder slice: it drives the slice's a/b/cin and consumes its combinational sum/cout/overflow.

## Interface
Parameters:
- WIDTH, 16, bits per adder slice; must match the slice width.
- WORDS, 4, number of slices per operand; legal range is WORDS ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operand request valid.
- in_ready  out  1  sequencer can accept a request.
- in_a  in  WIDTH*WORDS  operand A.
- in_b  in  WIDTH*WORDS  operand B.
- in_cin  in  1  carry-in for add; ignored for sub.
- in_sub  in  1  1 = A−B, 0 = A+B+cin.
- add_a  out  WIDTH  slice operand A, to the adder.
- add_b  out  WIDTH  slice operand B (already inverted for sub).
- add_cin  out  1  slice carry-in.
- add_sum  in  WIDTH  slice sum, combinational from the adder.
- add_cout  in  1  slice carry-out.
- add_overflow  in  1  slice signed overflow.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH*WORDS  wide result.
- out_cout  out  1  final carry; for sub, 1 = no borrow.
- out_overflow  out  1  signed overflow of the full-width operation.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1; add_a, add_b and add_cin are driven to 0.
  - On in_valid, latch A, and latch B (B inverted when in_sub=1).
  - Set carry = in_sub ? 1 : in_cin, set idx=0, go to RUN.
- RUN:
  - in_ready=0; drive add_a = A[idx], add_b = B[idx], add_cin = carry.
  - Each edge: out_sum[idx] ← add_sum, carry ← add_cout.
  - If idx==WORDS−1: out_cout ← add_cout, out_overflow ← add_overflow, go to DONE. Otherwise idx+1.
- DONE:
  - out_valid=1; slice outputs are driven to 0.
  - When out_ready=1, go to IDLE. A new request is not accepted in the same cycle.
- Width rules:
  - idx is $clog2(WORDS) bits, minimum 1, and never wraps past WORDS−1.
  - out_overflow reflects only the most-significant slice.
  - Intermediate slice overflows are discarded.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_overflow=0, idx=0, carry=0.
- Reset mid-RUN or mid-DONE aborts the operation; the partial result is never presented.
- in_valid is ignored outside IDLE. Operand inputs are sampled only on the accepting edge.

## Timing
- Handshakes: a request is accepted at the edge where in_valid & in_ready, and a result is consumed at the edge where out_valid & out_ready.
- Accept at edge E0. RUN occupies the cycles after E0, E1 … EWORDS. out_valid is high in the cycle after EWORDS.
- Latency from accept to out_valid is WORDS+1 cycles. The minimum request period is WORDS+2 cycles.
- The adder path is combinational within a cycle. add_* outputs are decoded from registered state only; there is no in→out combinational path.
- out_sum, out_cout and out_overflow hold stable while out_valid=1 and out_ready=0.
- WORDS=1: a single RUN cycle, and out_valid appears 2 cycles after accept.

## Structure
- Shared package adder_pkg:
  - state enum {IDLE, RUN, DONE}.
  - DEFAULT_WIDTH=16, DEFAULT_WORDS=4.
  - op encoding OP_ADD=0, OP_SUB=1.
- No sub-module inside this block. The adder slice is instantiated beside it at the parent level and connected through the add_* ports. The bench also uses this arrangement.

## Test plan
All cases use WIDTH=16, WORDS=4.
- Add across slices: A=0x0000_0000_0000_FFFF, B=0x1, cin=0 → out_sum=0x0000_0000_0001_0000, cout=0, ovf=0. out_valid is high exactly 5 cycles after accept.
- Full wrap: A=0xFFFF_FFFF_FFFF_FFFF, B=0x1 → out_sum=0, cout=1, ovf=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=0x1 → out_sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract with borrow: in_sub=1, A=5, B=7 → out_sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. The bench checks add_cin=1 in the first RUN cycle.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 → outputs stay stable, in_ready=0, and the second request is accepted only after the result is consumed.
- Reset mid-RUN: assert rst_n=0 while idx=2 → the next cycle shows IDLE, in_ready=1, out_valid=0, out_sum=0. A following add of 3+4 returns 7.
